// File: rtl/control_unit_pkg.sv
// ============================================================================
// Module      : control_unit_pkg
// Description : Shared types and encodings for the control unit: FSM states,
//               instruction classes, opcode/ext fields, ALU operation codes
//               and datapath select codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package control_unit_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  // How an instruction moves through EXECUTE
  typedef enum logic [1:0] {
    CLS_WRITEBACK  = 2'd0,  // ALU result written in a separate WRITEBACK cycle
    CLS_EXEC_WRITE = 2'd1,  // register written directly in EXECUTE (moves)
    CLS_COMPARE    = 2'd2,  // flags only, no register write
    CLS_ILLEGAL    = 2'd3
  } instr_class_t;

  // Primary opcodes, instruction[15:12]
  localparam logic [3:0] OPC_REG   = 4'h0;
  localparam logic [3:0] OPC_ANDI  = 4'h1;
  localparam logic [3:0] OPC_ORI   = 4'h2;
  localparam logic [3:0] OPC_XORI  = 4'h3;
  localparam logic [3:0] OPC_ADDI  = 4'h5;
  localparam logic [3:0] OPC_SHIFT = 4'h8;
  localparam logic [3:0] OPC_SUBI  = 4'h9;
  localparam logic [3:0] OPC_CMPI  = 4'hB;
  localparam logic [3:0] OPC_MOVI  = 4'hD;
  localparam logic [3:0] OPC_LUI   = 4'hF;

  // Extended opcodes, instruction[7:4]
  localparam logic [3:0] EXT_LSHI0 = 4'h0;
  localparam logic [3:0] EXT_AND   = 4'h1;
  localparam logic [3:0] EXT_LSHI1 = 4'h1;
  localparam logic [3:0] EXT_OR    = 4'h2;
  localparam logic [3:0] EXT_XOR   = 4'h3;
  localparam logic [3:0] EXT_LSH   = 4'h4;
  localparam logic [3:0] EXT_ADD   = 4'h5;
  localparam logic [3:0] EXT_SUB   = 4'h9;
  localparam logic [3:0] EXT_CMP   = 4'hB;
  localparam logic [3:0] EXT_MOV   = 4'hD;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_CMP   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_XOR   = 3'd5;
  localparam logic [2:0] ALU_SHIFT = 3'd6;

  // ALU A-operand select
  localparam logic [1:0] ALU_A_PC       = 2'd0;
  localparam logic [1:0] ALU_A_SRC      = 2'd1;
  localparam logic [1:0] ALU_A_IMM_SEXT = 2'd2;
  localparam logic [1:0] ALU_A_IMM_ZEXT = 2'd3;

  // ALU B-operand select
  localparam logic ALU_B_DEST = 1'b0;
  localparam logic ALU_B_ONE  = 1'b1;

  // Register write-data select
  localparam logic [1:0] WD_RESULT   = 2'd0;
  localparam logic [1:0] WD_SRC      = 2'd1;
  localparam logic [1:0] WD_IMM_ZEXT = 2'd2;
  localparam logic [1:0] WD_IMM_UP   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/control_decoder.sv
// ============================================================================
// Module      : control_decoder
// Description : Combinational instruction classifier. Maps an instruction
//               word to its execution class, ALU operation, A-operand select,
//               register write-data select, status update and legality.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_decoder
  import control_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] instruction,
  output instr_class_t     instr_class,
  output logic [2:0]       alu_operation,
  output logic [1:0]       alu_a_select,
  output logic [1:0]       write_data_select,
  output logic             status_update,
  output logic             legal
);

  logic [3:0] opcode;
  logic [3:0] ext;
  logic       unused_fields;

  assign opcode        = instruction[15:12];
  assign ext           = instruction[7:4];
  // Register and immediate fields are consumed by the datapath, not here
  assign unused_fields = ^{instruction[11:8], instruction[3:0]};
  assign legal         = (instr_class != CLS_ILLEGAL);

  // Classify the instruction and pick its execute-phase controls
  always_comb begin
    instr_class       = CLS_ILLEGAL;
    alu_operation     = ALU_ADD;
    alu_a_select      = ALU_A_SRC;
    write_data_select = WD_RESULT;
    status_update     = 1'b0;
    case (opcode)
      OPC_REG: begin
        case (ext)
          EXT_ADD: begin instr_class = CLS_WRITEBACK; alu_operation = ALU_ADD; status_update = 1'b1; end
          EXT_SUB: begin instr_class = CLS_WRITEBACK; alu_operation = ALU_SUB; status_update = 1'b1; end
          EXT_CMP: begin instr_class = CLS_COMPARE;   alu_operation = ALU_CMP; status_update = 1'b1; end
          EXT_AND: begin instr_class = CLS_WRITEBACK; alu_operation = ALU_AND; end
          EXT_OR:  begin instr_class = CLS_WRITEBACK; alu_operation = ALU_OR;  end
          EXT_XOR: begin instr_class = CLS_WRITEBACK; alu_operation = ALU_XOR; end
          EXT_MOV: begin instr_class = CLS_EXEC_WRITE; write_data_select = WD_SRC; end
          default: instr_class = CLS_ILLEGAL;
        endcase
      end
      OPC_ADDI: begin instr_class = CLS_WRITEBACK; alu_a_select = ALU_A_IMM_SEXT; alu_operation = ALU_ADD; status_update = 1'b1; end
      OPC_SUBI: begin instr_class = CLS_WRITEBACK; alu_a_select = ALU_A_IMM_SEXT; alu_operation = ALU_SUB; status_update = 1'b1; end
      OPC_CMPI: begin instr_class = CLS_COMPARE;   alu_a_select = ALU_A_IMM_SEXT; alu_operation = ALU_CMP; status_update = 1'b1; end
      OPC_ANDI: begin instr_class = CLS_WRITEBACK; alu_a_select = ALU_A_IMM_ZEXT; alu_operation = ALU_AND; end
      OPC_ORI:  begin instr_class = CLS_WRITEBACK; alu_a_select = ALU_A_IMM_ZEXT; alu_operation = ALU_OR;  end
      OPC_XORI: begin instr_class = CLS_WRITEBACK; alu_a_select = ALU_A_IMM_ZEXT; alu_operation = ALU_XOR; end
      OPC_MOVI: begin instr_class = CLS_EXEC_WRITE; alu_a_select = ALU_A_IMM_SEXT; write_data_select = WD_IMM_ZEXT; end
      OPC_LUI:  begin instr_class = CLS_EXEC_WRITE; write_data_select = WD_IMM_UP; end
      OPC_SHIFT: begin
        if (ext == EXT_LSH) begin
          instr_class   = CLS_WRITEBACK;
          alu_a_select  = ALU_A_SRC;
          alu_operation = ALU_SHIFT;
        end else if ((ext == EXT_LSHI0) || (ext == EXT_LSHI1)) begin
          instr_class   = CLS_WRITEBACK;
          alu_a_select  = ALU_A_IMM_SEXT;
          alu_operation = ALU_SHIFT;
        end
      end
      default: instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle Moore controller (FETCH, DECODE, EXECUTE,
//               WRITEBACK, HALT) driving datapath selects and write strobes.
//               Build option CONTROL_UNIT_ILLEGAL_HALT_EN: when defined an
//               illegal instruction parks the core in HALT; otherwise it runs
//               as a NOP and halted stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
  import control_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] instruction,
  input  logic             memory_ready,
  output logic [1:0]       alu_a_select,
  output logic             alu_b_select,
  output logic [2:0]       alu_operation,
  output logic             program_counter_write_enable,
  output logic             instruction_write_enable,
  output logic             status_write_enable,
  output logic             register_write_enable,
  output logic [1:0]       register_write_data_select,
  output logic             halted
);

  state_t       state_q;
  state_t       state_d;
  instr_class_t dec_class;
  logic [2:0]   dec_alu_operation;
  logic [1:0]   dec_alu_a_select;
  logic [1:0]   dec_write_data_select;
  logic         dec_status_update;
  logic         dec_legal;

  control_decoder #(
    .WIDTH (WIDTH)
  ) u_decoder (
    .instruction       (instruction),
    .instr_class       (dec_class),
    .alu_operation     (dec_alu_operation),
    .alu_a_select      (dec_alu_a_select),
    .write_data_select (dec_write_data_select),
    .status_update     (dec_status_update),
    .legal             (dec_legal)
  );

  // State register; reset always lands in FETCH, including from HALT
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs; reset gates every output to 0 immediately
  always_comb begin
    state_d                      = state_q;
    alu_a_select                 = ALU_A_PC;
    alu_b_select                 = ALU_B_DEST;
    alu_operation                = ALU_ADD;
    program_counter_write_enable = 1'b0;
    instruction_write_enable     = 1'b0;
    status_write_enable          = 1'b0;
    register_write_enable        = 1'b0;
    register_write_data_select   = WD_RESULT;
    halted                       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (memory_ready) begin
          instruction_write_enable = 1'b1;
          state_d                  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // PC increment happens for every instruction, legal or not
        alu_a_select                 = ALU_A_PC;
        alu_b_select                 = ALU_B_ONE;
        alu_operation                = ALU_ADD;
        program_counter_write_enable = 1'b1;
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
        state_d = dec_legal ? ST_EXECUTE : ST_HALT;
`else
        state_d = ST_EXECUTE;
`endif
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        if (dec_legal) begin
          alu_a_select        = dec_alu_a_select;
          alu_b_select        = ALU_B_DEST;
          alu_operation       = dec_alu_operation;
          status_write_enable = dec_status_update;
          case (dec_class)
            CLS_WRITEBACK: state_d = ST_WRITEBACK;
            CLS_EXEC_WRITE: begin
              register_write_enable      = 1'b1;
              register_write_data_select = dec_write_data_select;
            end
            default: state_d = ST_FETCH;
          endcase
        end
      end
      ST_WRITEBACK: begin
        register_write_enable      = 1'b1;
        register_write_data_select = WD_RESULT;
        state_d                    = ST_FETCH;
      end
      ST_HALT: begin
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
        halted  = 1'b1;
        state_d = ST_HALT;
`else
        state_d = ST_FETCH;
`endif
      end
      default: state_d = ST_FETCH;
    endcase
    if (reset) begin
      state_d                      = ST_FETCH;
      alu_a_select                 = ALU_A_PC;
      alu_b_select                 = ALU_B_DEST;
      alu_operation                = ALU_ADD;
      program_counter_write_enable = 1'b0;
      instruction_write_enable     = 1'b0;
      status_write_enable          = 1'b0;
      register_write_enable        = 1'b0;
      register_write_data_select   = WD_RESULT;
      halted                       = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module      : tb_control_unit
// Description : Scoreboard bench for control_unit. Stimulus pushes the
//               expected output vector (with a care mask) for each cycle;
//               a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        memory_ready = 1'b1;
  logic [15:0] instruction = 16'h0151;
  logic [1:0]  alu_a_select;
  logic        alu_b_select;
  logic [2:0]  alu_operation;
  logic        program_counter_write_enable;
  logic        instruction_write_enable;
  logic        status_write_enable;
  logic        register_write_enable;
  logic [1:0]  register_write_data_select;
  logic        halted;

  control_unit #(
    .WIDTH (16)
  ) dut (
    .clock                        (clock),
    .reset                        (reset),
    .instruction                  (instruction),
    .memory_ready                 (memory_ready),
    .alu_a_select                 (alu_a_select),
    .alu_b_select                 (alu_b_select),
    .alu_operation                (alu_operation),
    .program_counter_write_enable (program_counter_write_enable),
    .instruction_write_enable     (instruction_write_enable),
    .status_write_enable          (status_write_enable),
    .register_write_enable        (register_write_enable),
    .register_write_data_select   (register_write_data_select),
    .halted                       (halted)
  );

  always #5 clock = ~clock;

  // Output vector: {a[1:0], b, op[2:0], pc_we, ir_we, st_we, rf_we, wsel[1:0], halted}
  localparam logic [12:0] V_ZERO = 13'h0000;
  localparam logic [12:0] V_IW   = 13'h0020;
  localparam logic [12:0] V_DEC  = 13'h0440;
  localparam logic [12:0] V_HALT = 13'h0001;
  localparam logic [12:0] M_FULL = 13'h1FFF;
  localparam logic [12:0] M_STB  = 13'h0079;
  localparam logic [12:0] M_ALU  = 13'h1F80;
  localparam logic [12:0] M_WS   = 13'h0006;

  typedef struct packed {
    logic [12:0] e;
    logic [12:0] m;
  } exp_t;

  exp_t   exp_q[$];
  string  name_q[$];
  exp_t   cur;
  string  cur_nm;
  int     n_tests = 0;
  int     n_fail  = 0;

  logic [12:0] act;
  assign act = {alu_a_select, alu_b_select, alu_operation,
                program_counter_write_enable, instruction_write_enable,
                status_write_enable, register_write_enable,
                register_write_data_select, halted};

  function automatic logic [12:0] v(input logic [1:0] a, input logic b,
                                    input logic [2:0] op, input logic pc,
                                    input logic iw, input logic sw,
                                    input logic rw, input logic [1:0] ws,
                                    input logic h);
    return {a, b, op, pc, iw, sw, rw, ws, h};
  endfunction

  // Monitor: compare the DUT outputs of each cycle against the queued entry
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      cur    = exp_q.pop_front();
      cur_nm = name_q.pop_front();
      n_tests++;
      if (((act ^ cur.e) & cur.m) !== 13'h0000) begin
        n_fail++;
        $display("FAIL %s: outputs %h, expected %h (care mask %h)", cur_nm, act, cur.e, cur.m);
      end
      n_tests++;
      if ($countones({program_counter_write_enable, instruction_write_enable,
                      register_write_enable}) > 1) begin
        n_fail++;
        $display("FAIL %s write-enable exclusivity: pc/ir/rf = %b%b%b, expected at most one set",
                 cur_nm, program_counter_write_enable, instruction_write_enable,
                 register_write_enable);
      end
    end
  end

  task automatic cyc(input logic r, input logic mr, input logic [15:0] ins,
                     input logic [12:0] e, input logic [12:0] m, input string nm);
    @(posedge clock);
    #1;
    reset        = r;
    memory_ready = mr;
    instruction  = ins;
    exp_q.push_back({e, m});
    name_q.push_back(nm);
  endtask

  // One full instruction: fetch, decode, execute and optional writeback
  task automatic run(input logic [15:0] ins, input logic [12:0] ex,
                     input logic [12:0] exm, input bit wb, input string nm);
    cyc(1'b0, 1'b1, ins, V_IW,  M_FULL, {nm, " fetch"});
    cyc(1'b0, 1'b1, ins, V_DEC, M_FULL, {nm, " decode"});
    cyc(1'b0, 1'b1, ins, ex,    exm,    {nm, " execute"});
    if (wb) cyc(1'b0, 1'b1, ins, v(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0),
                M_STB | M_WS, {nm, " writeback"});
  endtask

  initial begin
    // Reset with memory_ready high: every output must stay 0
    cyc(1'b1, 1'b1, 16'h0151, V_ZERO, M_FULL, "reset cycle 0");
    cyc(1'b1, 1'b1, 16'h0151, V_ZERO, M_FULL, "reset cycle 1");

    run(16'h0151, v(2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0), M_STB | M_ALU, 1'b1, "ADD");

    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 16'h0291, V_ZERO, M_FULL, "fetch stall");
    run(16'h0291, v(2'd1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0), M_STB | M_ALU, 1'b1, "SUB");

    run(16'hB2FF, v(2'd2, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0), M_STB | M_ALU, 1'b0, "CMPI");
    run(16'hF3AB, v(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0), M_STB | M_WS,  1'b0, "LUI");
    run(16'h1234, v(2'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0), M_STB | M_ALU, 1'b1, "ANDI");
    run(16'h0131, v(2'd1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0), M_STB | M_ALU, 1'b1, "XOR");
    run(16'h01D2, v(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0), M_STB | M_WS,  1'b0, "MOV");
    run(16'hD145, v(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0), M_STB | M_WS,  1'b0, "MOVI");
    run(16'h8140, v(2'd1, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0), M_STB | M_ALU, 1'b1, "LSH");
    run(16'h8210, v(2'd2, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0), M_STB | M_ALU, 1'b1, "LSHI");

    // Reset pulsed in WRITEBACK of an ADD aborts it; FETCH follows release
    cyc(1'b0, 1'b1, 16'h0151, V_IW,  M_FULL, "ADD-abort fetch");
    cyc(1'b0, 1'b1, 16'h0151, V_DEC, M_FULL, "ADD-abort decode");
    cyc(1'b0, 1'b1, 16'h0151, v(2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0),
        M_STB | M_ALU, "ADD-abort execute");
    cyc(1'b1, 1'b1, 16'h0151, V_ZERO, M_FULL, "reset in writeback");
    run(16'h0151, v(2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0), M_STB | M_ALU, 1'b1, "ADD after reset");

    // Illegal instruction
    cyc(1'b0, 1'b1, 16'h4000, V_IW,  M_FULL, "illegal fetch");
    cyc(1'b0, 1'b1, 16'h4000, V_DEC, M_FULL, "illegal decode");
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
    for (int i = 0; i < 12; i++)
      cyc(1'b0, 1'b1, 16'h4000, V_HALT, M_FULL, "halted");
    cyc(1'b1, 1'b1, 16'h4000, V_ZERO, M_FULL, "reset clears halt");
    cyc(1'b0, 1'b1, 16'h0151, V_IW,   M_FULL, "fetch after halt");
`else
    cyc(1'b0, 1'b1, 16'h4000, V_ZERO, M_STB | M_WS, "illegal nop execute");
    cyc(1'b0, 1'b1, 16'h0151, V_IW,   M_FULL, "fetch after illegal");
`endif

    // Let the monitor drain the last entry
    @(posedge clock);
    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
